hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
- Producer side of the EX-stage operand-forwarding interface.
- Tracks the destination registers of instructions in flight through the EX and MEM stages.
- Registers the Forward_A/Forward_B mux selects for the instruction about to enter EX.
- Detects load-use hazards and issues a one-cycle stall with bubble insertion.
- Sits beside the ID/EX pipeline register, between decode and the EX-stage forwarding muxes.

Parameters:
- REG_ADDR_W, 5, width of register specifiers.
- CNT_W, 32, width of the stall performance counter when compiled in.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  REG_ADDR_W  source register A of the ID instruction.
- id_rt  input  REG_ADDR_W  source register B of the ID instruction.
- id_uses_rt  input  1  rt is read as a source (R-type, store, branch).
- id_dst  input  REG_ADDR_W  destination of the ID instruction, already resolved to rd or rt.
- id_reg_write  input  1  ID instruction writes the register file.
- id_mem_read  input  1  ID instruction is a load.
- flush  input  1  kill the ID instruction this cycle (taken branch or jump).
- Forward_A  output  2  EX operand A select: 00 reg1, 01 mem_wb_write_back_result, 10 ex_mem_alu_result; 11 is never driven.
- Forward_B  output  2  same encoding, for operand B and store data.
- stall  output  1  hold the PC and IF/ID; bubble ID/EX (combinational).
- stall_count  output  CNT_W  number of stall cycles (see Optional Feature).

Behaviour:
- State per tracked stage:
  - EX slot: ex_dst, ex_wr, ex_ld.
  - MEM slot: mem_dst, mem_wr.
  - Forward_A and Forward_B are held in output registers.
- Reset: all slot fields = 0, Forward_A = Forward_B = 00, stall = 0, stall_count = 0.
- Each rising edge, when not in reset:
  - The MEM slot takes the EX slot.
  - The EX slot takes the ID fields, or a bubble (all zero) if `stall | flush | !id_valid`.
- Hazard match:
  - A source matches a slot when its write flag is 1, its dst equals the source, and the dst is nonzero.
  - Register 0 is never forwarded or stalled on.
  - rt participates only when id_uses_rt = 1.
- Stall (combinational): `stall = id_valid & !flush & ex_ld & ex_wr & (rs match EX slot | rt match EX slot)`.
- Forward select registered at the edge, so it is valid while the instruction occupies EX:
  - If stall, flush or !id_valid: the next select is 00.
  - Otherwise, for each source:
    - EX-slot match gives 10.
    - Else MEM-slot match gives 01.
    - Else 00.
  - The EX slot has priority over the MEM slot (the youngest producer wins).
- Load-use: the stall cycle inserts one bubble. On the next cycle the load sits in the MEM slot, so the consumer receives 01 (write-back forward). Exactly one stall cycle per load-use, never two.
- Flush has priority over stall: with both conditions present, stall = 0 and a bubble is inserted.
- Reset mid-operation: all in-flight tracking is discarded and no stale select survives.
- Latency: 1 cycle from ID inputs to the Forward outputs; stall has 0 cycles of latency.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- With the macro defined:
  - stall_count increments by 1 on each clock edge where stall = 1 and reset = 0.
  - It saturates at all-ones rather than wrapping.
  - It clears to 0 on reset.
- Without the macro: stall_count is tied to 0 and no counter flops exist.

Test Plan:
- `add $3,$1,$2` followed by `sub $4,$3,$5` → during sub in EX, Forward_A = 10, Forward_B = 00, stall never 1.
- `add $3,$1,$2`; nop; `or $6,$7,$3` → during or in EX, Forward_B = 01, Forward_A = 00.
- `lw $8,0($9)` followed by `add $10,$8,$8` → stall = 1 for exactly one cycle with a bubble inserted; add in EX sees Forward_A = Forward_B = 01; stall_count = 1 with HAZARD_PERF_CNT_EN, 0 without.
- `add $0,$1,$2` followed by `add $4,$0,$0` → Forward_A = Forward_B = 00, no stall.
- Back-to-back `addi $5,$5,1` three times → the third sees Forward_A = 10 (EX beats MEM); `addi` with id_uses_rt = 0 never yields a nonzero Forward_B.
- `lw $8` then a consumer with flush = 1 in the same cycle → stall = 0, bubble inserted, next select 00; then assert reset mid-sequence → all outputs 0 on the following edge.

Source files
------------

// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if: ID-stage hazard inputs and EX-stage forwarding/stall outputs.
interface hazard_forward_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W = 32
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_dst;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  flush;
    logic [1:0]            Forward_A;
    logic [1:0]            Forward_B;
    logic                  stall;
    logic [CNT_W-1:0]      stall_count;
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_reg_write, id_mem_read, flush,
        input  Forward_A, Forward_B, stall, stall_count
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_reg_write, id_mem_read, flush,
        output Forward_A, Forward_B, stall, stall_count
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX/MEM destination tracking, registered forward selects, load-use stall.
// Optional saturating stall counter enabled by HAZARD_PERF_CNT_EN.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic reset,
    hazard_forward_unit_if.slave bus
);
    logic [REG_ADDR_W-1:0] ex_dst_q, ex_dst_d, mem_dst_q, mem_dst_d;
    logic                  ex_wr_q, ex_wr_d, ex_ld_q, ex_ld_d, mem_wr_q, mem_wr_d;
    logic [1:0]            fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic                  rs_ex, rt_ex, rs_mem, rt_mem, stall, bubble;
    always_comb begin
        rs_ex   = ex_wr_q && ex_dst_q == bus.id_rs && |bus.id_rs;
        rt_ex   = bus.id_uses_rt && ex_wr_q && ex_dst_q == bus.id_rt && |bus.id_rt;
        rs_mem  = mem_wr_q && mem_dst_q == bus.id_rs && |bus.id_rs;
        rt_mem  = bus.id_uses_rt && mem_wr_q && mem_dst_q == bus.id_rt && |bus.id_rt;
        stall   = bus.id_valid && !bus.flush && ex_ld_q && ex_wr_q && (rs_ex || rt_ex);
        bubble  = stall || bus.flush || !bus.id_valid;
        ex_dst_d  = bubble ? '0 : bus.id_dst;
        ex_wr_d   = !bubble && bus.id_reg_write;
        ex_ld_d   = !bubble && bus.id_mem_read;
        mem_dst_d = ex_dst_q;
        mem_wr_d  = ex_wr_q;
        // youngest producer (EX slot) wins over MEM
        fwd_a_d = bubble ? 2'b00 : rs_ex ? 2'b10 : rs_mem ? 2'b01 : 2'b00;
        fwd_b_d = bubble ? 2'b00 : rt_ex ? 2'b10 : rt_mem ? 2'b01 : 2'b00;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_dst_q  <= '0;
            ex_wr_q   <= 1'b0;
            ex_ld_q   <= 1'b0;
            mem_dst_q <= '0;
            mem_wr_q  <= 1'b0;
            fwd_a_q   <= 2'b00;
            fwd_b_q   <= 2'b00;
        end else begin
            ex_dst_q  <= ex_dst_d;
            ex_wr_q   <= ex_wr_d;
            ex_ld_q   <= ex_ld_d;
            mem_dst_q <= mem_dst_d;
            mem_wr_q  <= mem_wr_d;
            fwd_a_q   <= fwd_a_d;
            fwd_b_q   <= fwd_b_d;
        end
    end
    assign bus.Forward_A = fwd_a_q;
    assign bus.Forward_B = fwd_b_q;
    assign bus.stall     = stall;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign bus.stall_count = cnt_q;
`else
    assign bus.stall_count = {CNT_W{1'b0}};
`endif
endmodule
